data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the LEGv8 datapath: the slave end of the load/store control fields (mem_cs, mem_write_en, size) that the load/store control unit drives. It accepts one request at a time and performs it byte-serially on an internal byte-wide array. Reads return a zero-extended, little-endian 64-bit result on the data bus. Completion is signalled with a one-cycle done pulse so the multi-state control unit can advance.

## Interface
- ADDR_W, 12, byte-address width of the internal array (2^ADDR_W bytes)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req  in  1  request strobe, sampled in IDLE only
- mem_cs  in  2  chip select; 2'b01 = data memory, all other codes ignored
- mem_write_en  in  1  1 = store, 0 = load
- size  in  2  2'b11 = 8 bytes (doubleword); any other code = 1 byte
- address  in  64  byte address; only address[ADDR_W-1:0] used
- data_in  in  64  store data; byte k = data_in[8k+7:8k]
- data_out  out  64  load result, zero-extended, held until next load completes
- data_oe  out  1  bus drive enable for data_out (tri-state select)
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle misalignment flag, coincident with done

## Operation
- Clock/reset: one clock; reset is asynchronous and active-high. Reset values: busy 0, done 0, err 0, data_oe 0, data_out 0, FSM IDLE, beat counter 0. Array contents are not reset.
- Accept rule:
  - In IDLE with req=1 and mem_cs=2'b01, capture address, data_in, size and mem_write_en into internal registers.
  - req is ignored while busy; requests are not queued.
  - req with any other mem_cs is ignored.
- Beat count N: N=8 for size 2'b11, otherwise N=1.
- Misalignment: N=8 and address[2:0]≠0.
  - No array access takes place.
  - Go to DONE with err=1. data_out is unchanged.
- FSM:
  - IDLE -> ACCESS on accept (aligned).
  - IDLE -> DONE on accept (misaligned).
  - ACCESS stays for N cycles, beat counter 0..N-1, then -> DONE.
  - DONE -> IDLE unconditionally.
- Per ACCESS beat k:
  - Byte address = (captured address + k) mod 2^ADDR_W, so accesses wrap at the top of the array.
  - Store: write captured byte k to the array.
  - Load: read the byte into bits [8k+7:8k] of an assembly register.
- Load completion: on entering DONE, data_out <= assembly register with upper bytes zero (byte load yields {56'b0, byte}).
- data_oe:
  - Set to 1 on entering DONE for a successful load.
  - Stays 1 until the next accepted request.
  - Is 0 for stores and misaligned requests.
- Reset mid-operation returns to IDLE immediately. Bytes already written stay written; the remaining bytes are not written. No done pulse is issued.

## Timing
- Request accepted at rising edge T; busy=1 from T.
- Aligned access:
  - ACCESS occupies cycles T+1..T+N (one byte per cycle).
  - done=1 during cycle T+N+1 only; busy falls at the end of that cycle.
  - Latency from accept to done: 2 cycles for a byte, 9 cycles for a doubleword.
- Misaligned access: done=1 and err=1 in cycle T+1.
- Earliest next accept: the edge ending the DONE cycle's successor; back-to-back requests are spaced by N+2 cycles.
- data_out and data_oe change only on the edge entering DONE (load) or on accept (data_oe cleared). They are stable during DONE.
- Read of a byte written in the same request is not defined; a load issued after a store's done sees the stored data.

## Test plan
- Byte store/load: store size 01, address 0x010, data_in 0xFFFF_FFFF_FFFF_FFA5; then load size 01 at 0x010 -> done at T+2, data_out = 0x0000_0000_0000_00A5, data_oe=1, err=0.
- Doubleword store/load, little-endian: store 0x0123_4567_89AB_CDEF at 0x020 -> done at T+9. Byte load at 0x020 returns 0xEF; byte load at 0x027 returns 0x01; doubleword load at 0x020 returns 0x0123_4567_89AB_CDEF.
- Misaligned: doubleword store at 0x023 -> done=1 and err=1 at T+1. Subsequent doubleword load at 0x020 shows memory unchanged.
- Ignored requests:
  - req held high with new address during busy -> only the first request is performed, and exactly one done pulse is issued.
  - req with mem_cs=2'b10 -> no busy, no done.
- Wrap-around: with ADDR_W=12, store byte 0x5A at 0xFFF and byte 0x3C at 0x000. A doubleword load at 0xFF8 returns 0x5A in bits [63:56]; the store at 0x000 is independent.
- Reset mid-store: start doubleword store of 0x1111_1111_1111_1111 over zeroed memory at 0x040 and assert reset during the 3rd ACCESS beat -> all outputs 0 immediately, no done. A reload returns bytes 0-1 = 0x11 (possibly byte 2) and the upper bytes still 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Byte-serial data-memory responder for the LEGv8 load/store path.
// One request at a time; loads return zero-extended little-endian data.
module data_mem_responder #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic [1:0]  i_mem_cs,
  input  logic        i_mem_write_en,
  input  logic [1:0]  i_size,
  input  logic [63:0] i_address,
  input  logic [63:0] i_data_in,
  output logic [63:0] o_data_out,
  output logic        o_data_oe,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic [63:0]       r_asm;
  logic              r_we;
  logic              r_n8;
  logic [2:0]        r_beat;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_data_oe;
  logic [63:0]       r_data_out;
  logic [7:0]        r_mem [0:(1<<ADDR_W)-1];

  logic              w_accept;
  logic              w_misaligned;
  logic              w_last_beat;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_byte_addr;
  logic [7:0]        w_rd_byte;
  logic [7:0]        w_wr_byte;
  logic [63:0]       w_asm_next;
  logic              w_unused_addr;

  always_comb begin
    w_accept      = (r_state == S_IDLE) && i_req && (i_mem_cs == 2'b01);
    w_misaligned  = (i_size == 2'b11) && (i_address[2:0] != 3'b000);
    w_last_beat   = !r_n8 || (r_beat == 3'd7);
    w_wr_en       = (r_state == S_ACCESS) && r_we;
    // Address arithmetic is ADDR_W bits wide so beats wrap at the top of the array.
    w_byte_addr   = r_addr + ADDR_W'(r_beat);
    w_rd_byte     = r_mem[w_byte_addr];
    w_wr_byte     = r_wdata[{r_beat, 3'b000} +: 8];
    w_asm_next    = r_asm;
    w_asm_next[{r_beat, 3'b000} +: 8] = w_rd_byte;
    w_unused_addr = ^i_address[63:ADDR_W];
  end

  // Array has no reset; writes stop as soon as reset forces the FSM out of ACCESS.
  always_ff @(posedge i_clock) begin
    if (w_wr_en) begin
      r_mem[w_byte_addr] <= w_wr_byte;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_asm      <= '0;
      r_we       <= 1'b0;
      r_n8       <= 1'b0;
      r_beat     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_data_oe  <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr    <= i_address[ADDR_W-1:0];
            r_wdata   <= i_data_in;
            r_we      <= i_mem_write_en;
            r_n8      <= (i_size == 2'b11);
            r_asm     <= '0;
            r_beat    <= '0;
            r_busy    <= 1'b1;
            r_data_oe <= 1'b0;
            if (w_misaligned) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          r_asm <= w_asm_next;
          if (w_last_beat) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_beat  <= '0;
            if (!r_we) begin
              r_data_out <= w_asm_next;
              r_data_oe  <= 1'b1;
            end
          end else begin
            r_beat <= r_beat + 3'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_data_out = r_data_out;
  assign o_data_oe  = r_data_oe;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus
// randomized traffic against a byte-array reference model.
module tb_data_mem_responder;
  localparam int AW  = 12;
  localparam int MSZ = 1 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  cs  = 2'b00;
  logic        we  = 1'b0;
  logic [1:0]  sz  = 2'b00;
  logic [63:0] addr = '0;
  logic [63:0] din  = '0;
  logic [63:0] data_out;
  logic        data_oe, busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [0:MSZ-1];
  logic [63:0] ref_dout = '0;
  logic        ref_oe   = 1'b0;

  data_mem_responder #(.ADDR_W(AW)) dut (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_mem_cs(cs),
    .i_mem_write_en(we), .i_size(sz), .i_address(addr), .i_data_in(din),
    .o_data_out(data_out), .o_data_oe(data_oe), .o_busy(busy),
    .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_load(input logic [63:0] a, input bit n8);
    logic [63:0] v;
    int n;
    v = '0;
    n = n8 ? 8 : 1;
    for (int k = 0; k < n; k++)
      v = v | (64'(ref_mem[(int'(a[AW-1:0]) + k) % MSZ]) << (8 * k));
    return v;
  endfunction

  // Updates the model for one accepted request and returns expected latency/err.
  task automatic model_apply(input logic w, input bit n8, input logic [63:0] a,
                             input logic [63:0] d, output int lat, output logic e);
    if (n8 && a[2:0] != 3'b000) begin
      lat = 1; e = 1'b1; ref_oe = 1'b0;
    end else begin
      lat = n8 ? 9 : 2; e = 1'b0;
      if (w) begin
        for (int k = 0; k < (n8 ? 8 : 1); k++)
          ref_mem[(int'(a[AW-1:0]) + k) % MSZ] = d[8*k +: 8];
        ref_oe = 1'b0;
      end else begin
        ref_dout = model_load(a, n8);
        ref_oe   = 1'b1;
      end
    end
  endtask

  // Starts and ends at a negedge; returns observations of one request.
  task automatic run_req(input logic w, input logic [1:0] s, input logic [63:0] a,
                         input logic [63:0] d, input bit hold, output int lat,
                         output logic e, output logic [63:0] dout, output logic oe,
                         output int ndone, output bit busy_ok);
    lat = -1; e = 1'b0; dout = '0; oe = 1'b0; ndone = 0; busy_ok = 1'b1;
    we = w; sz = s; addr = a; din = d; cs = 2'b01; req = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 15 && lat < 0; c++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (hold) begin addr = {$urandom, $urandom}; din = {$urandom, $urandom}; end
      else req = 1'b0;
      if (done) begin
        ndone++; lat = c; e = err; dout = data_out; oe = data_oe; req = 1'b0;
      end
    end
    req = 1'b0;
    @(negedge clk);
    if (done) ndone++;
    if (busy) busy_ok = 1'b0;
    cs = 2'b00;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({busy, done, err, data_oe} !== 4'b0 || data_out !== 64'h0) begin
      errors++;
      $display("FAIL reset_async busy=%b done=%b err=%b oe=%b dout=%h exp all 0",
               busy, done, err, data_oe, data_out);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, err, data_oe} !== 4'b0 || data_out !== 64'h0) begin
      errors++;
      $display("FAIL reset_release busy=%b done=%b err=%b oe=%b dout=%h exp all 0",
               busy, done, err, data_oe, data_out);
    end
  endtask

  task automatic init_mem;
    int l, nd; logic e, o; logic [63:0] dv; bit bo;
    for (int i = 0; i < MSZ; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < MSZ / 8; i++)
      run_req(1'b1, 2'b11, 64'(i * 8), 64'h0, 1'b0, l, e, dv, o, nd, bo);
  endtask

  task automatic test_byte;
    int l, el, nd; logic e, ee, o; logic [63:0] dv; bit bo;
    model_apply(1'b1, 1'b0, 64'h010, 64'hFFFF_FFFF_FFFF_FFA5, el, ee);
    run_req(1'b1, 2'b01, 64'h010, 64'hFFFF_FFFF_FFFF_FFA5, 1'b0, l, e, dv, o, nd, bo);
    checks++;
    if (l !== 2 || e !== 1'b0 || o !== 1'b0 || !bo) begin
      errors++;
      $display("FAIL byte_store lat=%0d err=%b oe=%b busy_ok=%0d exp lat=2 err=0 oe=0 busy_ok=1", l, e, o, bo);
    end
    model_apply(1'b0, 1'b0, 64'h010, 64'h0, el, ee);
    run_req(1'b0, 2'b01, 64'h010, 64'h0, 1'b0, l, e, dv, o, nd, bo);
    checks++;
    if (l !== 2 || dv !== 64'hA5 || o !== 1'b1 || e !== 1'b0) begin
      errors++;
      $display("FAIL byte_load lat=%0d dout=%h oe=%b err=%b exp lat=2 dout=a5 oe=1 err=0", l, dv, o, e);
    end
  endtask

  task automatic test_dword;
    int l, el, nd; logic e, ee, o; logic [63:0] dv; bit bo;
    model_apply(1'b1, 1'b1, 64'h020, 64'h0123_4567_89AB_CDEF, el, ee);
    run_req(1'b1, 2'b11, 64'h020, 64'h0123_4567_89AB_CDEF, 1'b0, l, e, dv, o, nd, bo);
    checks++;
    if (l !== 9 || e !== 1'b0 || nd !== 1) begin
      errors++;
      $display("FAIL dword_store lat=%0d err=%b ndone=%0d exp lat=9 err=0 ndone=1", l, e, nd);
    end
    model_apply(1'b0, 1'b0, 64'h020, 64'h0, el, ee);
    run_req(1'b0, 2'b00, 64'h020, 64'h0, 1'b0, l, e, dv, o, nd, bo);
    checks++;
    if (dv !== 64'hEF) begin
      errors++; $display("FAIL dword_lsb dout=%h exp ef", dv);
    end
    model_apply(1'b0, 1'b0, 64'h027, 64'h0, el, ee);
    run_req(1'b0, 2'b10, 64'h027, 64'h0, 1'b0, l, e, dv, o, nd, bo);
    checks++;
    if (dv !== 64'h01) begin
      errors++; $display("FAIL dword_msb dout=%h exp 01", dv);
    end
    model_apply(1'b0, 1'b1, 64'h020, 64'h0, el, ee);
    run_req(1'b0, 2'b11, 64'h020, 64'h0, 1'b0, l, e, dv, o, nd, bo);
    checks++;
    if (l !== 9 || dv !== 64'h0123_4567_89AB_CDEF || o !== 1'b1) begin
      errors++;
      $display("FAIL dword_load lat=%0d dout=%h oe=%b exp lat=9 dout=0123456789abcdef oe=1", l, dv, o);
    end
  endtask

  task automatic test_misaligned;
    int l, el, nd; logic e, ee, o; logic [63:0] dv; bit bo;
    model_apply(1'b1, 1'b1, 64'h023, 64'hDEAD_BEEF_CAFE_F00D, el, ee);
    run_req(1'b1, 2'b11, 64'h023, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, l, e, dv, o, nd, bo);
    checks++;
    if (l !== 1 || e !== 1'b1 || o !== 1'b0 || nd !== 1 || dv !== 64'h0123_4567_89AB_CDEF) begin
      errors++;
      $display("FAIL misaligned lat=%0d err=%b oe=%b ndone=%0d dout=%h exp lat=1 err=1 oe=0 ndone=1 dout=0123456789abcdef",
               l, e, o, nd, dv);
    end
    model_apply(1'b0, 1'b1, 64'h020, 64'h0, el, ee);
    run_req(1'b0, 2'b11, 64'h020, 64'h0, 1'b0, l, e, dv, o, nd, bo);
    checks++;
    if (dv !== 64'h0123_4567_89AB_CDEF || e !== 1'b0) begin
      errors++; $display("FAIL misaligned_nowrite dout=%h err=%b exp 0123456789abcdef err=0", dv, e);
    end
  endtask

  task automatic test_ignored;
    int l, el, nd, nbusy, ndn; logic e, ee, o; logic [63:0] dv; bit bo;
    model_apply(1'b1, 1'b0, 64'h030, 64'h77, el, ee);
    run_req(1'b1, 2'b00, 64'h030, 64'h77, 1'b1, l, e, dv, o, nd, bo);
    checks++;
    if (l !== 2 || nd !== 1) begin
      errors++; $display("FAIL held_req lat=%0d ndone=%0d exp lat=2 ndone=1", l, nd);
    end
    model_apply(1'b0, 1'b0, 64'h030, 64'h0, el, ee);
    run_req(1'b0, 2'b00, 64'h030, 64'h0, 1'b0, l, e, dv, o, nd, bo);
    checks++;
    if (dv !== 64'h77) begin
      errors++; $display("FAIL held_req_data dout=%h exp 77", dv);
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 1) continue;
      nbusy = 0; ndn = 0;
      cs = 2'(c); we = 1'b1; sz = 2'b01; addr = 64'h030; din = 64'h99; req = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (busy) nbusy++;
        if (done) ndn++;
      end
      req = 1'b0; cs = 2'b00;
      checks++;
      if (nbusy != 0 || ndn != 0) begin
        errors++; $display("FAIL bad_cs cs=%0d busy_cycles=%0d done_cycles=%0d exp 0 0", c, nbusy, ndn);
      end
    end
    model_apply(1'b0, 1'b0, 64'h030, 64'h0, el, ee);
    run_req(1'b0, 2'b00, 64'h030, 64'h0, 1'b0, l, e, dv, o, nd, bo);
    checks++;
    if (dv !== 64'h77) begin
      errors++; $display("FAIL bad_cs_nowrite dout=%h exp 77", dv);
    end
  endtask

  task automatic test_wrap;
    int l, el, nd; logic e, ee, o; logic [63:0] dv; bit bo;
    model_apply(1'b1, 1'b0, 64'hFFF, 64'h5A, el, ee);
    run_req(1'b1, 2'b01, 64'hFFF, 64'h5A, 1'b0, l, e, dv, o, nd, bo);
    model_apply(1'b1, 1'b0, 64'h000, 64'h3C, el, ee);
    run_req(1'b1, 2'b01, 64'h000, 64'h3C, 1'b0, l, e, dv, o, nd, bo);
    model_apply(1'b0, 1'b1, 64'hFF8, 64'h0, el, ee);
    run_req(1'b0, 2'b11, 64'hFF8, 64'h0, 1'b0, l, e, dv, o, nd, bo);
    checks++;
    if (dv[63:56] !== 8'h5A || dv !== ref_dout) begin
      errors++; $display("FAIL wrap_dword dout=%h exp %h", dv, ref_dout);
    end
    model_apply(1'b0, 1'b0, 64'hABCD_0000_0000_1000, 64'h0, el, ee);
    run_req(1'b0, 2'b01, 64'hABCD_0000_0000_1000, 64'h0, 1'b0, l, e, dv, o, nd, bo);
    checks++;
    if (dv !== 64'h3C) begin
      errors++; $display("FAIL wrap_upper_ignored dout=%h exp 3c", dv);
    end
  endtask

  task automatic test_reset_mid;
    int l, el, nd, ndn; logic e, ee, o; logic [63:0] dv; bit bo;
    ndn = 0;
    we = 1'b1; sz = 2'b11; addr = 64'h040; din = 64'h1111_1111_1111_1111; cs = 2'b01; req = 1'b1;
    @(posedge clk);
    @(negedge clk); req = 1'b0; cs = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, data_oe} !== 4'b0 || data_out !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b err=%b oe=%b dout=%h exp all 0",
               busy, done, err, data_oe, data_out);
    end
    repeat (2) begin @(negedge clk); if (done) ndn++; end
    rst = 1'b0;
    repeat (12) begin @(negedge clk); if (done) ndn++; end
    checks++;
    if (ndn != 0) begin
      errors++; $display("FAIL reset_mid_nodone done_cycles=%0d exp 0", ndn);
    end
    ref_mem[12'h040] = 8'h11; ref_mem[12'h041] = 8'h11;
    ref_dout = '0; ref_oe = 1'b0;
    model_apply(1'b0, 1'b1, 64'h040, 64'h0, el, ee);
    run_req(1'b0, 2'b11, 64'h040, 64'h0, 1'b0, l, e, dv, o, nd, bo);
    checks++;
    if (dv !== 64'h1111 && dv !== 64'h11_1111) begin
      errors++; $display("FAIL reset_mid_partial dout=%h exp 1111 or 111111", dv);
    end
    ref_mem[12'h042] = dv[23:16];
    ref_dout = dv;
  endtask

  task automatic test_random;
    int l, el, nd; logic e, ee, o, w; logic [1:0] s; logic [63:0] dv, a, d; bit bo;
    for (int i = 0; i < 80; i++) begin
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      a[11:0] = 12'hFC0 + 12'($urandom_range(0, 63));
      if (s == 2'b11 && $urandom_range(0, 3) != 0) a[2:0] = 3'b000;
      d = {$urandom, $urandom};
      model_apply(w, s == 2'b11, a, d, el, ee);
      run_req(w, s, a, d, 1'b0, l, e, dv, o, nd, bo);
      checks++;
      if (l !== el || e !== ee || nd !== 1 || !bo) begin
        errors++;
        $display("FAIL rnd_ctrl i=%0d lat=%0d err=%b ndone=%0d busy_ok=%0d exp lat=%0d err=%b ndone=1 busy_ok=1",
                 i, l, e, nd, bo, el, ee);
      end
      checks++;
      if (dv !== ref_dout || o !== ref_oe) begin
        errors++;
        $display("FAIL rnd_data i=%0d we=%b sz=%0d a=%h dout=%h oe=%b exp dout=%h oe=%b",
                 i, w, s, a, dv, o, ref_dout, ref_oe);
      end
    end
  endtask

  task automatic test_back_to_back;
    int l, el, nd; logic e, ee, o; logic [63:0] dv, d; bit bo;
    d = {$urandom, $urandom};
    model_apply(1'b1, 1'b1, 64'h100, d, el, ee);
    run_req(1'b1, 2'b11, 64'h100, d, 1'b0, l, e, dv, o, nd, bo);
    model_apply(1'b0, 1'b1, 64'h100, 64'h0, el, ee);
    run_req(1'b0, 2'b11, 64'h100, 64'h0, 1'b0, l, e, dv, o, nd, bo);
    checks++;
    if (l !== 9 || dv !== d || o !== 1'b1) begin
      errors++; $display("FAIL b2b lat=%0d dout=%h oe=%b exp lat=9 dout=%h oe=1", l, dv, o, d);
    end
    model_apply(1'b1, 1'b0, 64'h108, 64'h42, el, ee);
    run_req(1'b1, 2'b01, 64'h108, 64'h42, 1'b0, l, e, dv, o, nd, bo);
    checks++;
    if (l !== 2 || o !== 1'b0 || dv !== d) begin
      errors++; $display("FAIL b2b_store lat=%0d oe=%b dout=%h exp lat=2 oe=0 dout=%h", l, o, dv, d);
    end
  endtask

  initial begin
    test_reset;
    init_mem;
    test_byte;
    test_dword;
    test_misaligned;
    test_ignored;
    test_wrap;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
